// File: rtl/rv_pkg.sv
// Shared definitions for the single-cycle RV32I subset core: opcodes, control
// encodings, and the decode / immediate / ALU helpers used by the top level.
package rv_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLT = 4'b0101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    result_src_e result_src;
    imm_src_e    imm_src;
    alu_ctrl_e   alu_control;
    logic        branch;
    logic        jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write:   1'b0,
    mem_write:   1'b0,
    alu_src:     1'b0,
    result_src:  RES_ALU,
    imm_src:     IMM_I,
    alu_control: ALU_ADD,
    branch:      1'b0,
    jump:        1'b0
  };

  // Maps funct3 to an ALU operation for both R-type and I-type ALU forms.
  function automatic logic alu_op_from_f3(input logic [2:0] f3, output alu_ctrl_e op);
    op = ALU_ADD;
    case (f3)
      3'b000:  begin op = ALU_ADD; return 1'b1; end
      3'b111:  begin op = ALU_AND; return 1'b1; end
      3'b110:  begin op = ALU_OR;  return 1'b1; end
      3'b100:  begin op = ALU_XOR; return 1'b1; end
      3'b010:  begin op = ALU_SLT; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t     c;
    alu_ctrl_e op;
    logic      ok;
    logic [2:0] f3;
    logic [6:0] f7;
    // NOTE: every output starts from a full default so no path leaves a field
    // unassigned; in an always_comb the same omission would infer a latch.
    c  = CTRL_NOP;
    f3 = instr[14:12];
    f7 = instr[31:25];
    case (instr[6:0])
      OP_R: begin
        ok = alu_op_from_f3(f3, op);
        if (f7 == 7'b0100000) begin
          ok = (f3 == 3'b000);
          op = ALU_SUB;
        end else if (f7 != 7'b0000000) begin
          ok = 1'b0;
        end
        if (ok) begin
          c.reg_write   = 1'b1;
          c.alu_control = op;
        end
      end
      OP_I: begin
        if (alu_op_from_f3(f3, op)) begin
          c.reg_write   = 1'b1;
          c.alu_src     = 1'b1;
          c.alu_control = op;
        end
      end
      OP_LW: begin
        if (f3 == 3'b010) begin
          c.reg_write  = 1'b1;
          c.alu_src    = 1'b1;
          c.result_src = RES_MEM;
        end
      end
      OP_SW: begin
        if (f3 == 3'b010) begin
          c.mem_write = 1'b1;
          c.alu_src   = 1'b1;
          c.imm_src   = IMM_S;
        end
      end
      OP_BEQ: begin
        if (f3 == 3'b000) begin
          c.branch      = 1'b1;
          c.imm_src     = IMM_B;
          c.alu_control = ALU_SUB;
        end
      end
      OP_JAL: begin
        c.reg_write  = 1'b1;
        c.jump       = 1'b1;
        c.imm_src    = IMM_J;
        c.result_src = RES_PC4;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_src_e src);
    case (src)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input alu_ctrl_e op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem.sv
// Word-addressed data memory: synchronous write, combinational read, no reset.
module dmem #(
  parameter int WORDS = 1024,
  localparam int AW   = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] memory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];

endmodule

// File: rtl/imem.sv
// Instruction memory with a combinational read port. Program images are normally
// loaded through hierarchy; the write port is tied off by the top level.
module imem #(
  parameter int WORDS = 1024,
  localparam int AW   = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);

  logic [31:0] memory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (prog_we) memory[prog_addr] <= prog_data;
  end

  assign rdata = memory[addr];

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit register file: two combinational read ports, one write port.
// x0 always reads zero; a same-cycle read of the written register sees the old value.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] Register [0:31];

  // NOTE: this array is architectural state that must come up zeroed, so it is
  // reset; the instruction and data memories deliberately are not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) Register[i] <= 32'h0;
    end else if (we && (wa != 5'd0)) begin
      Register[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : Register[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : Register[ra2];

endmodule

// File: rtl/single_cycle_top.sv
// Single-cycle RV32I subset core: each instruction is fetched, executed and
// retired in one clock. Memory depths must be powers of two.
module single_cycle_top
  import rv_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic clk,
  input  logic rst
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr;
  ctrl_t       ctrl;
  logic [31:0] imm;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] mem_rdata;
  logic [31:0] pc_plus4, pc_target;
  logic [31:0] result;

  imem #(.WORDS(IMEM_WORDS)) I_mem (
    .clk       (clk),
    .prog_we   (1'b0),
    .prog_addr ({IAW{1'b0}}),
    .prog_data (32'h0),
    .addr      (pc_q[IAW+1:2]),
    .rdata     (instr)
  );

  reg_file Reg_file (
    .clk (clk),
    .rst (rst),
    .we  (ctrl.reg_write),
    .ra1 (instr[19:15]),
    .ra2 (instr[24:20]),
    .wa  (instr[11:7]),
    .wd  (result),
    .rd1 (rs1_val),
    .rd2 (rs2_val)
  );

  // The store is gated by reset because the data memory has no reset of its own.
  dmem #(.WORDS(DMEM_WORDS)) D_mem (
    .clk   (clk),
    .we    (ctrl.mem_write & rst),
    .addr  (alu_result[DAW+1:2]),
    .wdata (rs2_val),
    .rdata (mem_rdata)
  );

  always_comb begin
    ctrl       = decode(instr);
    imm        = imm_gen(instr, ctrl.imm_src);
    src_b      = ctrl.alu_src ? imm : rs2_val;
    alu_result = alu(rs1_val, src_b, ctrl.alu_control);
    zero       = (alu_result == 32'h0);
    pc_plus4   = pc_q + 32'd4;
    pc_target  = pc_q + imm;

    case (ctrl.result_src)
      RES_MEM: result = mem_rdata;
      RES_PC4: result = pc_plus4;
      default: result = alu_result;
    endcase

    if (ctrl.jump || (ctrl.branch && zero)) pc_d = pc_target;
    else                                    pc_d = pc_plus4;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values that existed before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

endmodule

// File: tb/tb_single_cycle_top.sv
// Self-checking bench for single_cycle_top: a table of single-instruction
// vectors plus short hand-written programs for reset and memory behaviour.
module tb_single_cycle_top;

  logic clk = 1'b0;
  logic rst = 1'b1;

  single_cycle_top dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [4:0]  chk_reg;
    logic [31:0] exp_reg;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  reg_idx;
    logic [31:0] exp_reg;
    logic [31:0] exp_pc;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 16; i++) begin
      dut.I_mem.memory[i] = 32'h0;
      dut.D_mem.memory[i] = 32'h0;
    end
  endtask

  // Assert reset on a falling clock edge; registers clear asynchronously.
  task automatic start_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    clear_mems();
  endtask

  // Pops one scoreboard entry and compares it against the DUT state.
  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
      return;
    end
    e = sb_q.pop_front();
    check({e.name, "_pc"}, dut.pc_q, e.exp_pc);
    check({e.name, "_reg"}, dut.Reg_file.Register[e.reg_idx], e.exp_reg);
  endtask

  task automatic apply_vec(input vec_t v);
    start_reset();
    dut.I_mem.memory[0]        = v.instr;
    dut.Reg_file.Register[1]   = v.x1;
    dut.Reg_file.Register[2]   = v.x2;
    sb_q.push_back('{name: v.name, reg_idx: v.chk_reg, exp_reg: v.exp_reg, exp_pc: v.exp_pc});
    #1 rst = 1'b1;
    @(posedge clk);
    #1 sb_compare();
  endtask

  initial begin
    logic [31:0] acc;

    vecs.push_back('{"addi",      32'h00110093, 32'h0,        32'd32,       5'd1, 32'd33,       32'h4});
    vecs.push_back('{"sub",       32'h402081B3, 32'd5,        32'd7,        5'd3, 32'hFFFFFFFE, 32'h4});
    vecs.push_back('{"add_wrap",  32'h002081B3, 32'hFFFFFFFF, 32'd2,        5'd3, 32'h1,        32'h4});
    vecs.push_back('{"and",       32'h0020F1B3, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3, 32'hF000F000, 32'h4});
    vecs.push_back('{"or",        32'h0020E1B3, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3, 32'hFFF0FFF0, 32'h4});
    vecs.push_back('{"xor",       32'h0020C1B3, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3, 32'h0FF00FF0, 32'h4});
    vecs.push_back('{"slt_neg",   32'h0020A1B3, 32'hFFFFFFFF, 32'd1,        5'd3, 32'h1,        32'h4});
    vecs.push_back('{"slt_pos",   32'h0020A1B3, 32'd1,        32'hFFFFFFFF, 5'd3, 32'h0,        32'h4});
    vecs.push_back('{"slti_min",  32'hFFF0A193, 32'h80000000, 32'h0,        5'd3, 32'h1,        32'h4});
    vecs.push_back('{"andi",      32'h0FF0F193, 32'h12345678, 32'h0,        5'd3, 32'h78,       32'h4});
    vecs.push_back('{"ori_neg",   32'hF000E193, 32'h12,       32'h0,        5'd3, 32'hFFFFFF12, 32'h4});
    vecs.push_back('{"xori_not",  32'hFFF0C193, 32'h0,        32'h0,        5'd3, 32'hFFFFFFFF, 32'h4});
    vecs.push_back('{"addi_x0",   32'h00500013, 32'h0,        32'h0,        5'd0, 32'h0,        32'h4});
    vecs.push_back('{"beq_taken", 32'h00000463, 32'h0,        32'h0,        5'd0, 32'h0,        32'h8});
    vecs.push_back('{"beq_not",   32'h00008463, 32'd1,        32'h0,        5'd1, 32'd1,        32'h4});
    vecs.push_back('{"beq_back",  32'hFE000CE3, 32'h0,        32'h0,        5'd0, 32'h0,        32'hFFFFFFF8});
    vecs.push_back('{"jal_fwd",   32'h010000EF, 32'h0,        32'h0,        5'd1, 32'h4,        32'h10});
    vecs.push_back('{"jal_back",  32'hFFDFF06F, 32'h0,        32'h0,        5'd0, 32'h0,        32'hFFFFFFFC});
    vecs.push_back('{"unknown",   32'hFFFFFFFF, 32'd7,        32'd9,        5'd1, 32'd7,        32'h4});
    vecs.push_back('{"bad_f7",    32'h022081B3, 32'd5,        32'd7,        5'd3, 32'h0,        32'h4});

    // Reset: scribble registers, then assert reset and confirm they clear.
    #1;
    for (int i = 1; i < 32; i++) dut.Reg_file.Register[i] = 32'hA5A50000 + i;
    #1 rst = 1'b0;
    #1 clear_mems();
    check("rst_pc", dut.pc_q, 32'h0);
    acc = 32'h0;
    for (int i = 1; i < 32; i++) acc = acc | dut.Reg_file.Register[i];
    check("rst_regs_zero", acc, 32'h0);
    repeat (2) @(posedge clk);
    #1 check("rst_hold_pc", dut.pc_q, 32'h0);

    // Memory of zeros decodes as NOPs: PC advances by 4 per edge.
    @(negedge clk);
    for (int i = 1; i <= 3; i++)
      sb_q.push_back('{name: $sformatf("nop_step%0d", i), reg_idx: 5'd1, exp_reg: 32'h0,
                       exp_pc: 32'(4 * i)});
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 sb_compare();
    end

    foreach (vecs[i]) apply_vec(vecs[i]);

    // sw then lw; the first edge runs while still in reset and must not store.
    start_reset();
    dut.I_mem.memory[0] = 32'h00512023;
    dut.I_mem.memory[1] = 32'h00012303;
    dut.D_mem.memory[0] = 32'h12345678;
    @(posedge clk);
    #1 check("rst_no_store", dut.D_mem.memory[0], 32'h12345678);
    check("rst_no_pc_step", dut.pc_q, 32'h0);
    dut.Reg_file.Register[2] = 32'd32;
    dut.Reg_file.Register[5] = 32'hDEADBEEF;
    rst = 1'b1;
    @(posedge clk);
    #1 check("sw_mem", dut.D_mem.memory[8], 32'hDEADBEEF);
    check("sw_pc", dut.pc_q, 32'h4);
    @(posedge clk);
    #1 check("lw_x6", dut.Reg_file.Register[6], 32'hDEADBEEF);
    check("lw_pc", dut.pc_q, 32'h8);

    // Data address wraps modulo the memory depth: 0x1020 aliases word 8.
    start_reset();
    dut.I_mem.memory[0]      = 32'h0053A023;
    dut.I_mem.memory[1]      = 32'h00012303;
    dut.Reg_file.Register[2] = 32'd32;
    dut.Reg_file.Register[5] = 32'hCAFEF00D;
    dut.Reg_file.Register[7] = 32'h00001020;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("wrap_mem", dut.D_mem.memory[8], 32'hCAFEF00D);
    check("wrap_lw_x6", dut.Reg_file.Register[6], 32'hCAFEF00D);

    // Back-to-back increments, then reset mid-program.
    start_reset();
    for (int i = 0; i < 8; i++) dut.I_mem.memory[i] = 32'h00108093;
    #1 rst = 1'b1;
    for (int i = 1; i <= 3; i++)
      sb_q.push_back('{name: $sformatf("inc%0d", i), reg_idx: 5'd1, exp_reg: 32'(i),
                       exp_pc: 32'(4 * i)});
    repeat (3) begin
      @(posedge clk);
      #1 sb_compare();
    end
    #2 rst = 1'b0;
    #1 check("midrst_pc", dut.pc_q, 32'h0);
    check("midrst_x1", dut.Reg_file.Register[1], 32'h0);
    @(posedge clk);
    #1 check("midrst_hold_pc", dut.pc_q, 32'h0);
    check("midrst_hold_x1", dut.Reg_file.Register[1], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("restart_x1", dut.Reg_file.Register[1], 32'h1);
    check("restart_pc", dut.pc_q, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
